// File: rtl/order_book.sv
// Single-instrument limit order book: order table, per-side price-level
// table and registered best bid/offer. One command is processed at a time
// through a fixed four-state sequence (IDLE, LOOKUP, APPLY, BBO).
module order_book #(
    parameter int PRICE_WIDTH      = 32,
    parameter int QTY_WIDTH        = 32,
    parameter int ORDER_ID_WIDTH   = 64,
    parameter int MAX_PRICE_LEVELS = 256,
    parameter int MAX_ORDERS       = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      add_valid,
    output logic                      add_ready,
    input  logic [ORDER_ID_WIDTH-1:0] add_order_id,
    input  logic                      add_side,
    input  logic [PRICE_WIDTH-1:0]    add_price,
    input  logic [QTY_WIDTH-1:0]      add_quantity,
    input  logic                      cancel_valid,
    output logic                      cancel_ready,
    input  logic [ORDER_ID_WIDTH-1:0] cancel_order_id,
    output logic                      cancel_found,
    input  logic                      exec_valid,
    output logic                      exec_ready,
    input  logic [ORDER_ID_WIDTH-1:0] exec_order_id,
    input  logic [QTY_WIDTH-1:0]      exec_quantity,
    output logic                      exec_found,
    output logic [PRICE_WIDTH-1:0]    best_bid,
    output logic [PRICE_WIDTH-1:0]    best_ask,
    output logic [QTY_WIDTH-1:0]      best_bid_qty,
    output logic [QTY_WIDTH-1:0]      best_ask_qty,
    output logic                      best_bid_valid,
    output logic                      best_ask_valid,
    output logic [15:0]               total_bid_levels,
    output logic [15:0]               total_ask_levels
);

    localparam int OIW = (MAX_ORDERS > 1) ? $clog2(MAX_ORDERS) : 1;
    localparam int LIW = (MAX_PRICE_LEVELS > 1) ? $clog2(MAX_PRICE_LEVELS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_APPLY, S_BBO} state_t;
    typedef enum logic [1:0] {CMD_ADD, CMD_CANCEL, CMD_EXEC} cmd_t;

    state_t state, state_next;
    logic   ready;
    logic   accept, do_lookup, do_apply, do_bbo;

    // Captured command
    cmd_t                      cmd_kind;
    logic [ORDER_ID_WIDTH-1:0] cmd_id;
    logic                      cmd_side;
    logic [PRICE_WIDTH-1:0]    cmd_price;
    logic [QTY_WIDTH-1:0]      cmd_qty;

    // Order table
    logic                      ord_valid [MAX_ORDERS];
    logic [ORDER_ID_WIDTH-1:0] ord_id    [MAX_ORDERS];
    logic                      ord_side  [MAX_ORDERS];
    logic [PRICE_WIDTH-1:0]    ord_price [MAX_ORDERS];
    logic [QTY_WIDTH-1:0]      ord_qty   [MAX_ORDERS];

    // Level table, first index is side (0 = bid, 1 = ask)
    logic                   lvl_valid [2][MAX_PRICE_LEVELS];
    logic [PRICE_WIDTH-1:0] lvl_price [2][MAX_PRICE_LEVELS];
    logic [QTY_WIDTH-1:0]   lvl_qty   [2][MAX_PRICE_LEVELS];
    logic [15:0]            lvl_count [2];

    // Combinational lookup results
    logic                   ord_hit_c, ord_free_c, lvl_hit_c, lvl_free_c;
    logic [OIW-1:0]         ord_idx_c, ord_free_idx_c;
    logic [LIW-1:0]         lvl_idx_c, lvl_free_idx_c;
    logic                   key_side;
    logic [PRICE_WIDTH-1:0] key_price;

    // Registered lookup results
    logic           lk_ord_hit, lk_ord_free, lk_lvl_hit, lk_lvl_free, lk_side;
    logic [OIW-1:0] lk_ord_idx, lk_ord_free_idx;
    logic [LIW-1:0] lk_lvl_idx, lk_lvl_free_idx;

    // Apply-stage arithmetic
    logic [QTY_WIDTH-1:0] cur_ord_qty, cur_lvl_qty, fill, ord_rem, lvl_sub, lvl_rem, lvl_sum;
    logic                 add_ok;

    // Best-price scan results
    logic                   bid_v_c, ask_v_c;
    logic [PRICE_WIDTH-1:0] bid_p_c, ask_p_c;
    logic [QTY_WIDTH-1:0]   bid_q_c, ask_q_c;

    assign add_ready    = ready;
    assign cancel_ready = ready;
    assign exec_ready   = ready;

    // State register; ready is registered alongside so it equals (state == IDLE)
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            ready <= 1'b1;
        end else begin
            state <= state_next;
            ready <= (state_next == S_IDLE);
        end
    end

    // Next-state logic: fixed walk through the pipeline once a command is accepted
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (add_valid || cancel_valid || exec_valid) state_next = S_LOOKUP;
            S_LOOKUP: state_next = S_APPLY;
            S_APPLY:  state_next = S_BBO;
            S_BBO:    state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
    end

    // Output decode: per-state enables for the datapath
    always_comb begin
        accept    = 1'b0;
        do_lookup = 1'b0;
        do_apply  = 1'b0;
        do_bbo    = 1'b0;
        case (state)
            S_IDLE:   accept    = add_valid || cancel_valid || exec_valid;
            S_LOOKUP: do_lookup = 1'b1;
            S_APPLY:  do_apply  = 1'b1;
            S_BBO:    do_bbo    = 1'b1;
            default:  ;
        endcase
    end

    // Command capture with add > cancel > exec priority
    always_ff @(posedge clk) begin
        if (accept) begin
            if (add_valid) begin
                cmd_kind  <= CMD_ADD;
                cmd_id    <= add_order_id;
                cmd_side  <= add_side;
                cmd_price <= add_price;
                cmd_qty   <= add_quantity;
            end else if (cancel_valid) begin
                cmd_kind  <= CMD_CANCEL;
                cmd_id    <= cancel_order_id;
                cmd_side  <= 1'b0;
                cmd_price <= '0;
                cmd_qty   <= '0;
            end else begin
                cmd_kind  <= CMD_EXEC;
                cmd_id    <= exec_order_id;
                cmd_side  <= 1'b0;
                cmd_price <= '0;
                cmd_qty   <= exec_quantity;
            end
        end
    end

    // Table search: id hit, first free order slot, side+price level hit, first free level
    // (cancel/exec take the level key from the matched order)
    always_comb begin
        ord_hit_c      = 1'b0;
        ord_idx_c      = '0;
        ord_free_c     = 1'b0;
        ord_free_idx_c = '0;
        for (int unsigned i = 0; i < MAX_ORDERS; i++) begin
            if (!ord_hit_c && ord_valid[i] && ord_id[i] == cmd_id) begin
                ord_hit_c = 1'b1;
                ord_idx_c = OIW'(i);
            end
            if (!ord_free_c && !ord_valid[i]) begin
                ord_free_c     = 1'b1;
                ord_free_idx_c = OIW'(i);
            end
        end
        key_side  = cmd_side;
        key_price = cmd_price;
        if (cmd_kind != CMD_ADD) begin
            key_side  = ord_side[ord_idx_c];
            key_price = ord_price[ord_idx_c];
        end
        lvl_hit_c      = 1'b0;
        lvl_idx_c      = '0;
        lvl_free_c     = 1'b0;
        lvl_free_idx_c = '0;
        for (int unsigned j = 0; j < MAX_PRICE_LEVELS; j++) begin
            if (!lvl_hit_c && lvl_valid[key_side][j] && lvl_price[key_side][j] == key_price) begin
                lvl_hit_c = 1'b1;
                lvl_idx_c = LIW'(j);
            end
            if (!lvl_free_c && !lvl_valid[key_side][j]) begin
                lvl_free_c     = 1'b1;
                lvl_free_idx_c = LIW'(j);
            end
        end
    end

    // Lookup register: freeze search results for the apply stage
    always_ff @(posedge clk) begin
        if (do_lookup) begin
            lk_ord_hit      <= ord_hit_c;
            lk_ord_idx      <= ord_idx_c;
            lk_ord_free     <= ord_free_c;
            lk_ord_free_idx <= ord_free_idx_c;
            lk_lvl_hit      <= lvl_hit_c;
            lk_lvl_idx      <= lvl_idx_c;
            lk_lvl_free     <= lvl_free_c;
            lk_lvl_free_idx <= lvl_free_idx_c;
            lk_side         <= key_side;
        end
    end

    // Apply arithmetic: saturating fill, level subtraction and wrapping level sum
    always_comb begin
        cur_ord_qty = ord_qty[lk_ord_idx];
        cur_lvl_qty = lvl_qty[lk_side][lk_lvl_idx];
        fill        = (cmd_qty < cur_ord_qty) ? cmd_qty : cur_ord_qty;
        ord_rem     = cur_ord_qty - fill;
        lvl_sub     = (cmd_kind == CMD_CANCEL) ? cur_ord_qty : fill;
        lvl_rem     = cur_lvl_qty - lvl_sub;
        lvl_sum     = cur_lvl_qty + cmd_qty;
        add_ok      = (cmd_qty != '0) && !lk_ord_hit && lk_ord_free && (lk_lvl_hit || lk_lvl_free);
    end

    // Table update; reset clears only the valid bits and level counts
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MAX_ORDERS; i++) ord_valid[i] <= 1'b0;
            for (int unsigned j = 0; j < MAX_PRICE_LEVELS; j++) begin
                lvl_valid[0][j] <= 1'b0;
                lvl_valid[1][j] <= 1'b0;
            end
            lvl_count[0] <= '0;
            lvl_count[1] <= '0;
        end else if (do_apply) begin
            case (cmd_kind)
                CMD_ADD: if (add_ok) begin
                    ord_valid[lk_ord_free_idx] <= 1'b1;
                    ord_id[lk_ord_free_idx]    <= cmd_id;
                    ord_side[lk_ord_free_idx]  <= cmd_side;
                    ord_price[lk_ord_free_idx] <= cmd_price;
                    ord_qty[lk_ord_free_idx]   <= cmd_qty;
                    if (lk_lvl_hit) begin
                        lvl_qty[lk_side][lk_lvl_idx] <= lvl_sum;
                    end else begin
                        lvl_valid[lk_side][lk_lvl_free_idx] <= 1'b1;
                        lvl_price[lk_side][lk_lvl_free_idx] <= cmd_price;
                        lvl_qty[lk_side][lk_lvl_free_idx]   <= cmd_qty;
                        lvl_count[lk_side] <= lvl_count[lk_side] + 16'd1;
                    end
                end
                CMD_CANCEL, CMD_EXEC: if (lk_ord_hit) begin
                    if (cmd_kind == CMD_CANCEL || ord_rem == '0) ord_valid[lk_ord_idx] <= 1'b0;
                    else ord_qty[lk_ord_idx] <= ord_rem;
                    if (lk_lvl_hit) begin
                        if (lvl_rem == '0) begin
                            lvl_valid[lk_side][lk_lvl_idx] <= 1'b0;
                            lvl_count[lk_side] <= lvl_count[lk_side] - 16'd1;
                        end else begin
                            lvl_qty[lk_side][lk_lvl_idx] <= lvl_rem;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Best-price scan: highest valid bid, lowest valid ask
    always_comb begin
        bid_v_c = 1'b0;
        bid_p_c = '0;
        bid_q_c = '0;
        ask_v_c = 1'b0;
        ask_p_c = '0;
        ask_q_c = '0;
        for (int unsigned j = 0; j < MAX_PRICE_LEVELS; j++) begin
            if (lvl_valid[0][j] && (!bid_v_c || lvl_price[0][j] > bid_p_c)) begin
                bid_v_c = 1'b1;
                bid_p_c = lvl_price[0][j];
                bid_q_c = lvl_qty[0][j];
            end
            if (lvl_valid[1][j] && (!ask_v_c || lvl_price[1][j] < ask_p_c)) begin
                ask_v_c = 1'b1;
                ask_p_c = lvl_price[1][j];
                ask_q_c = lvl_qty[1][j];
            end
        end
    end

    // Published BBO, level counts and per-command result flags
    always_ff @(posedge clk) begin
        if (rst) begin
            best_bid         <= '0;
            best_ask         <= '0;
            best_bid_qty     <= '0;
            best_ask_qty     <= '0;
            best_bid_valid   <= 1'b0;
            best_ask_valid   <= 1'b0;
            total_bid_levels <= '0;
            total_ask_levels <= '0;
            cancel_found     <= 1'b0;
            exec_found       <= 1'b0;
        end else if (do_bbo) begin
            best_bid         <= bid_p_c;
            best_ask         <= ask_p_c;
            best_bid_qty     <= bid_q_c;
            best_ask_qty     <= ask_q_c;
            best_bid_valid   <= bid_v_c;
            best_ask_valid   <= ask_v_c;
            total_bid_levels <= lvl_count[0];
            total_ask_levels <= lvl_count[1];
            if (cmd_kind == CMD_CANCEL) cancel_found <= lk_ord_hit;
            if (cmd_kind == CMD_EXEC)   exec_found   <= lk_ord_hit;
        end
    end

endmodule

// File: tb/tb_order_book.sv
// Scoreboarded bench for order_book: each command pushes its expected
// book snapshot, which is popped and compared once the command completes.
module tb_order_book;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        add_valid = 1'b0, cancel_valid = 1'b0, exec_valid = 1'b0;
    logic        add_ready, cancel_ready, exec_ready;
    logic [63:0] add_order_id = '0, cancel_order_id = '0, exec_order_id = '0;
    logic        add_side = 1'b0;
    logic [31:0] add_price = '0, add_quantity = '0, exec_quantity = '0;
    logic        cancel_found, exec_found;
    logic [31:0] best_bid, best_ask, best_bid_qty, best_ask_qty;
    logic        best_bid_valid, best_ask_valid;
    logic [15:0] total_bid_levels, total_ask_levels;

    always #5 clk = ~clk;

    order_book dut (
        .clk(clk), .rst(rst),
        .add_valid(add_valid), .add_ready(add_ready), .add_order_id(add_order_id),
        .add_side(add_side), .add_price(add_price), .add_quantity(add_quantity),
        .cancel_valid(cancel_valid), .cancel_ready(cancel_ready),
        .cancel_order_id(cancel_order_id), .cancel_found(cancel_found),
        .exec_valid(exec_valid), .exec_ready(exec_ready), .exec_order_id(exec_order_id),
        .exec_quantity(exec_quantity), .exec_found(exec_found),
        .best_bid(best_bid), .best_ask(best_ask),
        .best_bid_qty(best_bid_qty), .best_ask_qty(best_ask_qty),
        .best_bid_valid(best_bid_valid), .best_ask_valid(best_ask_valid),
        .total_bid_levels(total_bid_levels), .total_ask_levels(total_ask_levels)
    );

    typedef struct packed {
        logic        bid_v;
        logic [31:0] bid;
        logic [31:0] bid_qty;
        logic        ask_v;
        logic [31:0] ask;
        logic [31:0] ask_qty;
        logic [15:0] nbid;
        logic [15:0] nask;
        logic        cf;
        logic        ef;
    } bbo_t;

    typedef struct packed {
        logic [1:0]  kind;   // 0 add, 1 cancel, 2 exec
        logic [63:0] id;
        logic        side;
        logic [31:0] price;
        logic [31:0] qty;
        bbo_t        exp;
    } step_t;

    bbo_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    function automatic bbo_t mk(input logic bv, input int bp, input int bq, input logic av,
                                input int ap, input int aq, input int nb, input int na,
                                input logic cf, input logic ef);
        bbo_t b;
        b.bid_v = bv; b.bid = 32'(bp); b.bid_qty = 32'(bq);
        b.ask_v = av; b.ask = 32'(ap); b.ask_qty = 32'(aq);
        b.nbid = 16'(nb); b.nask = 16'(na); b.cf = cf; b.ef = ef;
        return b;
    endfunction

    function automatic step_t st(input logic [1:0] kind, input int id, input logic side,
                                 input int price, input int qty, input bbo_t exp);
        step_t s;
        s.kind = kind; s.id = 64'(id); s.side = side;
        s.price = 32'(price); s.qty = 32'(qty); s.exp = exp;
        return s;
    endfunction

    function automatic bbo_t observe();
        bbo_t b;
        b.bid_v = best_bid_valid; b.bid = best_bid; b.bid_qty = best_bid_qty;
        b.ask_v = best_ask_valid; b.ask = best_ask; b.ask_qty = best_ask_qty;
        b.nbid = total_bid_levels; b.nask = total_ask_levels;
        b.cf = cancel_found; b.ef = exec_found;
        return b;
    endfunction

    // Drive one command through the handshake and wait for ready to come back
    task automatic send(input step_t s, output int lat);
        int w;
        @(negedge clk);
        add_order_id = s.id; add_side = s.side; add_price = s.price; add_quantity = s.qty;
        cancel_order_id = s.id; exec_order_id = s.id; exec_quantity = s.qty;
        add_valid = (s.kind == 2'd0); cancel_valid = (s.kind == 2'd1); exec_valid = (s.kind == 2'd2);
        w = 0;
        while (!add_ready && w < 50) begin @(negedge clk); w++; end
        if (w >= 50) begin
            tests++; fails++;
            $display("FAIL ready_wait got=0 exp=1");
        end
        @(posedge clk); #1;
        add_valid = 1'b0; cancel_valid = 1'b0; exec_valid = 1'b0;
        lat = 0;
        while (!add_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        if (lat >= 50) begin
            tests++; fails++;
            $display("FAIL done_wait got=timeout exp=ready");
        end
    endtask

    task automatic test_reset();
        bbo_t obs;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        obs = observe();
        tests++;
        if (obs !== mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            fails++; $display("FAIL reset_outputs got=%h exp=%h", obs, mk(0,0,0,0,0,0,0,0,0,0));
        end
        tests++;
        if ({add_ready, cancel_ready, exec_ready} !== 3'b111) begin
            fails++; $display("FAIL reset_ready got=%b exp=111", {add_ready, cancel_ready, exec_ready});
        end
    endtask

    task automatic test_add();
        step_t s[$];
        bbo_t  obs, e;
        int    lat;
        s.push_back(st(0, 1, 0, 10000, 100, mk(1, 10000, 100, 0, 0, 0, 1, 0, 0, 0)));
        s.push_back(st(0, 2, 1, 10100, 50,  mk(1, 10000, 100, 1, 10100, 50, 1, 1, 0, 0)));
        s.push_back(st(0, 3, 0, 10000, 200, mk(1, 10000, 300, 1, 10100, 50, 1, 1, 0, 0)));
        s.push_back(st(0, 4, 0, 10050, 75,  mk(1, 10050, 75, 1, 10100, 50, 2, 1, 0, 0)));
        s.push_back(st(0, 5, 1, 10080, 25,  mk(1, 10050, 75, 1, 10080, 25, 2, 2, 0, 0)));
        foreach (s[k]) begin
            exp_q.push_back(s[k].exp);
            send(s[k], lat);
            obs = observe();
            e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL add[%0d] got=%h exp=%h", k, obs, e); end
            if (k == 0) begin
                tests++;
                if (lat != 3) begin fails++; $display("FAIL add_latency got=%0d exp=3", lat); end
            end
        end
    endtask

    task automatic test_cancel();
        step_t s[$];
        bbo_t  obs, e;
        int    lat;
        s.push_back(st(1, 4,   0, 0, 0, mk(1, 10000, 300, 1, 10080, 25, 1, 2, 1, 0)));
        s.push_back(st(1, 999, 0, 0, 0, mk(1, 10000, 300, 1, 10080, 25, 1, 2, 0, 0)));
        foreach (s[k]) begin
            exp_q.push_back(s[k].exp);
            send(s[k], lat);
            obs = observe();
            e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL cancel[%0d] got=%h exp=%h", k, obs, e); end
        end
    endtask

    task automatic test_exec();
        step_t s[$];
        bbo_t  obs, e;
        int    lat;
        s.push_back(st(2, 1,  0, 0, 30, mk(1, 10000, 270, 1, 10080, 25, 1, 2, 0, 1)));
        s.push_back(st(2, 5,  0, 0, 25, mk(1, 10000, 270, 1, 10100, 50, 1, 1, 0, 1)));
        s.push_back(st(2, 2,  0, 0, 80, mk(1, 10000, 270, 0, 0, 0, 1, 0, 0, 1)));
        s.push_back(st(2, 77, 0, 0, 5,  mk(1, 10000, 270, 0, 0, 0, 1, 0, 0, 0)));
        foreach (s[k]) begin
            exp_q.push_back(s[k].exp);
            send(s[k], lat);
            obs = observe();
            e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL exec[%0d] got=%h exp=%h", k, obs, e); end
        end
        repeat (6) @(posedge clk);
        #1 obs = observe();
        tests++;
        if (obs !== mk(1, 10000, 270, 0, 0, 0, 1, 0, 0, 0)) begin
            fails++; $display("FAIL idle_stable got=%h exp=%h", obs, mk(1,10000,270,0,0,0,1,0,0,0));
        end
    endtask

    task automatic test_drops();
        step_t s[$];
        bbo_t  obs, e;
        int    lat;
        s.push_back(st(0, 3, 0, 9000, 10,  mk(1, 10000, 270, 0, 0, 0, 1, 0, 0, 0)));
        s.push_back(st(0, 6, 0, 20000, 0,  mk(1, 10000, 270, 0, 0, 0, 1, 0, 0, 0)));
        s.push_back(st(2, 3, 0, 0, 0,      mk(1, 10000, 270, 0, 0, 0, 1, 0, 0, 1)));
        foreach (s[k]) begin
            exp_q.push_back(s[k].exp);
            send(s[k], lat);
            obs = observe();
            e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL drop[%0d] got=%h exp=%h", k, obs, e); end
        end
    endtask

    task automatic test_back_to_back();
        bbo_t  obs, e;
        int    lat, w;
        step_t s[$];
        @(negedge clk);
        add_order_id = 64'd7; add_side = 1'b1; add_price = 32'd10200; add_quantity = 32'd40;
        cancel_order_id = 64'd3;
        add_valid = 1'b1; cancel_valid = 1'b1;
        w = 0;
        while (!add_ready && w < 50) begin @(negedge clk); w++; end
        @(posedge clk); #1;
        add_valid = 1'b0;
        exp_q.push_back(mk(1, 10000, 270, 1, 10200, 40, 1, 1, 0, 1));
        exp_q.push_back(mk(1, 10000, 70, 1, 10200, 40, 1, 1, 1, 1));
        lat = 0;
        while (!add_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        tests++;
        if (lat != 3) begin fails++; $display("FAIL b2b_add_latency got=%0d exp=3", lat); end
        obs = observe();
        e = exp_q.pop_front();
        tests++;
        if (obs !== e) begin fails++; $display("FAIL b2b_add got=%h exp=%h", obs, e); end
        @(posedge clk); #1;
        tests++;
        if (add_ready !== 1'b0) begin fails++; $display("FAIL b2b_cancel_accept got=%b exp=0", add_ready); end
        cancel_valid = 1'b0;
        lat = 0;
        while (!add_ready && lat < 50) begin @(posedge clk); #1; lat++; end
        tests++;
        if (lat != 3) begin fails++; $display("FAIL b2b_cancel_latency got=%0d exp=3", lat); end
        obs = observe();
        e = exp_q.pop_front();
        tests++;
        if (obs !== e) begin fails++; $display("FAIL b2b_cancel got=%h exp=%h", obs, e); end
        s.push_back(st(1, 1, 0, 0, 0,  mk(0, 0, 0, 1, 10200, 40, 0, 1, 1, 1)));
        s.push_back(st(2, 7, 0, 0, 40, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1)));
        foreach (s[k]) begin
            exp_q.push_back(s[k].exp);
            send(s[k], lat);
            obs = observe();
            e = exp_q.pop_front();
            tests++;
            if (obs !== e) begin fails++; $display("FAIL drain[%0d] got=%h exp=%h", k, obs, e); end
        end
    endtask

    task automatic test_reset_abort();
        bbo_t obs, e;
        int   lat;
        @(negedge clk);
        add_order_id = 64'd8; add_side = 1'b0; add_price = 32'd777; add_quantity = 32'd9;
        add_valid = 1'b1;
        @(posedge clk); #1;
        add_valid = 1'b0;
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        #1 obs = observe();
        tests++;
        if (obs !== mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0)) begin
            fails++; $display("FAIL abort_outputs got=%h exp=%h", obs, mk(0,0,0,0,0,0,0,0,0,0));
        end
        tests++;
        if (add_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got=%b exp=1", add_ready); end
        exp_q.push_back(mk(1, 500, 5, 0, 0, 0, 1, 0, 0, 0));
        send(st(0, 8, 0, 500, 5, mk(1, 500, 5, 0, 0, 0, 1, 0, 0, 0)), lat);
        obs = observe();
        e = exp_q.pop_front();
        tests++;
        if (obs !== e) begin fails++; $display("FAIL abort_readd got=%h exp=%h", obs, e); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cancel();
        test_exec();
        test_drops();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
